// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI register-access sequencer.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT,
        HOLD,
        DONE
    } state_e;

    localparam logic       RW_READ    = 1'b1;
    localparam logic       RW_WRITE   = 1'b0;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;

endpackage

// File: rtl/spi_reg_sequencer.sv
// Register-access front end for a CPOL0/CPHA1 SPI byte master: frames one
// read/write command as an address byte plus 1..MAX_BYTES data bytes under a
// continuous chip select and returns one response per command.
// Optional build macro SPI_SEQ_TIMEOUT_EN enables the per-byte WAIT watchdog.
module spi_reg_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned CS_SETUP  = 2,
    parameter int unsigned CS_HOLD   = 2,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic [6:0]             cmd_addr,
    input  logic [2:0]             cmd_len,
    input  logic [8*MAX_BYTES-1:0] cmd_wdata,
    output logic                   rsp_valid,
    output logic [8*MAX_BYTES-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   cs_n,
    output logic                   spi_start,
    output logic [7:0]             spi_data_in,
    input  logic                   spi_busy,
    input  logic                   spi_new_data,
    input  logic [7:0]             spi_data_out
);

    localparam int unsigned DW   = 8 * MAX_BYTES;
    localparam int unsigned CMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned TW   = $clog2(TIMEOUT + 1);
`ifdef SPI_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0]      idx_q, idx_d;
    logic [3:0]      last_q;
    logic            pend_q, pend_d;
    logic            err_q, err_d;
    logic            rw_q;
    logic [6:0]      addr_q;
    logic [DW-1:0]   wdata_q;
    logic            accept_c;
    logic            store_c;
    logic [3:0]      eff_len_c;
    logic [7:0]      wr_byte_c;
    logic [7:0]      issue_byte_c;

    // Clamp requested length: 0 or oversize means a full MAX_BYTES frame.
    always_comb begin
        if (cmd_len == 3'd0 || 32'(cmd_len) > MAX_BYTES) eff_len_c = 4'(MAX_BYTES);
        else                                               eff_len_c = {1'b0, cmd_len};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and control strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        err_d    = err_q;
        accept_c = 1'b0;
        store_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept_c = 1'b1;
                    state_d  = SETUP;
                    cnt_d    = '0;
                    idx_d    = '0;
                    err_d    = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == CW'(CS_SETUP - 1)) begin
                    if (!spi_busy) state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ISSUE: begin
                state_d = WAIT;
                pend_d  = 1'b0;
                tmo_d   = '0;
            end
            WAIT: begin
                if (pend_q) begin
                    // byte done but master still busy: launch as soon as it frees
                    if (!spi_busy) state_d = ISSUE;
                end else if (spi_new_data) begin
                    store_c = 1'b1;
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == last_q) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else if (!spi_busy) begin
                        state_d = ISSUE;
                    end else begin
                        pend_d = 1'b1;
                    end
                end else if (TMO_EN && (tmo_q == TW'(TIMEOUT - 1))) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == CW'(CS_HOLD - 1)) state_d = DONE;
                else                           cnt_d   = cnt_q + CW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Byte to present on the next ISSUE: address byte, write byte or dummy.
    always_comb begin
        wr_byte_c = '0;
        for (int k = 0; k < int'(MAX_BYTES); k++) begin
            if (idx_d == 4'(k + 1)) wr_byte_c = wdata_q[8*k +: 8];
        end
        if (idx_d == 4'd0)          issue_byte_c = {rw_q, addr_q};
        else if (rw_q == RW_WRITE)  issue_byte_c = wr_byte_c;
        else                        issue_byte_c = DUMMY_BYTE;
    end

    // Datapath and registered outputs, aligned with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            tmo_q       <= '0;
            idx_q       <= '0;
            last_q      <= '0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_ready   <= 1'b0;
            cs_n        <= 1'b1;
            spi_start   <= 1'b0;
            spi_data_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            cmd_ready <= (state_d == IDLE);
            cs_n      <= !(state_d inside {SETUP, ISSUE, WAIT, HOLD});
            spi_start <= (state_d == ISSUE);
            if (state_d == ISSUE) spi_data_in <= issue_byte_c;
            rsp_valid <= (state_d == DONE);
            rsp_err   <= TMO_EN && (state_d == DONE) && err_d;
            if (accept_c) begin
                rw_q      <= cmd_rw;
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                last_q    <= eff_len_c;
                rsp_rdata <= '0;
            end else if (store_c && rw_q == RW_READ) begin
                // data byte k arrives while idx_q == k+1; address-byte result dropped
                for (int k = 0; k < int'(MAX_BYTES); k++) begin
                    if (idx_q == 4'(k + 1)) rsp_rdata[8*k +: 8] <= spi_data_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Bench for spi_reg_sequencer with a behavioural SPI byte master + slave model.
// Honours SPI_SEQ_TIMEOUT_EN for the watchdog scenario.
module tb_spi_reg_sequencer;

    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_rw = 1'b0;
    logic [6:0]    cmd_addr = '0;
    logic [2:0]    cmd_len = '0;
    logic [31:0]   cmd_wdata = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          cs_n;
    logic          spi_start;
    logic [7:0]    spi_data_in;
    logic          bm_busy;
    logic          bm_nd;
    logic [7:0]    bm_out;

    spi_reg_sequencer #(
        .MAX_BYTES(MB), .CS_SETUP(2), .CS_HOLD(2), .TIMEOUT(20)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cs_n(cs_n), .spi_start(spi_start), .spi_data_in(spi_data_in),
        .spi_busy(bm_busy), .spi_new_data(bm_nd), .spi_data_out(bm_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte master + slave model: 4-cycle byte, slave answers from miso_q.
    logic [39:0] miso_q = '0;
    int          drop_idx = -1;
    int          bm_cnt = 0;
    int          bm_idx = 0;
    always @(posedge clk) begin
        if (rst) begin
            bm_busy <= 1'b0;
            bm_nd   <= 1'b0;
            bm_out  <= '0;
            bm_cnt  <= 0;
            bm_idx  <= 0;
        end else begin
            bm_nd <= 1'b0;
            if (cs_n && !bm_busy) bm_idx <= 0;
            if (spi_start && !bm_busy) begin
                bm_busy <= 1'b1;
                bm_cnt  <= 4;
            end else if (bm_busy) begin
                if (bm_cnt == 1) begin
                    bm_busy <= 1'b0;
                    if (bm_idx != drop_idx) bm_nd <= 1'b1;
                    if (bm_idx < 5) bm_out <= miso_q[bm_idx*8 +: 8];
                    bm_idx <= bm_idx + 1;
                end
                bm_cnt <= bm_cnt - 1;
            end
        end
    end

    // Monitor, sampled on the falling edge.
    int          nmosi = 0, nrsp = 0, nacc = 0, ncs_rise = 0, cs_bad = 0;
    int          setup_cnt = 0, hold_cnt = 0;
    int          acc_cyc [4];
    int          rsp_cyc [4];
    logic [39:0] mosi = '0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic        cs_prev = 1'b1;
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                if (nacc < 4) acc_cyc[nacc] = cyc;
                nacc++;
            end
            if (spi_start) begin
                if (nmosi < 5) mosi[nmosi*8 +: 8] = spi_data_in;
                if (cs_n) cs_bad++;
                nmosi++;
            end
            if (!cs_n && nmosi == 0 && !spi_start) setup_cnt++;
            if (spi_start || bm_nd) hold_cnt = 0;
            else if (!cs_n)         hold_cnt++;
            if (cs_n && !cs_prev) ncs_rise++;
            if (rsp_valid) begin
                if (nrsp < 4) rsp_cyc[nrsp] = cyc;
                nrsp++;
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
            end
        end
        cs_prev = cs_n;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        nmosi = 0; nrsp = 0; nacc = 0; ncs_rise = 0; cs_bad = 0;
        setup_cnt = 0; hold_cnt = 0; mosi = '0;
        last_rdata = '0; last_err = 1'b0;
    endtask

    // Issue one command, wait for acceptance, then for its response (bounded).
    task automatic run_cmd(input logic rw, input logic [6:0] a, input logic [2:0] l,
                           input logic [31:0] wd, input logic [39:0] mi, input int budget);
        int n;
        @(posedge clk); #1;
        clear_mon();
        miso_q = mi;
        cmd_rw = rw; cmd_addr = a; cmd_len = l; cmd_wdata = wd; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (nrsp == 0 && n < budget) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        logic [39:0] miso;
        int          nbytes;
        logic [39:0] mosi;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        vecs[0] = '{1'b0, 7'h12, 3'd2, 32'h0000BEEF, 40'h0,          3, 40'h0000BEEF12, 32'h0};
        vecs[1] = '{1'b1, 7'h05, 3'd1, 32'h0,        40'h000000A500, 2, 40'h0000000085, 32'h000000A5};
        vecs[2] = '{1'b0, 7'h7F, 3'd0, 32'h44332211, 40'h0,          5, 40'h443322117F, 32'h0};
        vecs[3] = '{1'b1, 7'h33, 3'd7, 32'h0,        40'h44332211FF, 5, 40'h00000000B3, 32'h44332211};
        vecs[4] = '{1'b0, 7'h01, 3'd5, 32'hDEADBEEF, 40'h0,          5, 40'hDEADBEEF01, 32'h0};
        vecs[5] = '{1'b1, 7'h40, 3'd3, 32'hFFFFFFFF, 40'h00CCBBAA77, 4, 40'h00000000C0, 32'h00CCBBAA};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_cs_n", 64'(cs_n), 64'd1);
        chk("rst_spi_start", 64'(spi_start), 64'd0);
        chk("rst_spi_data_in", 64'(spi_data_in), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].rw, vecs[i].addr, vecs[i].len, vecs[i].wdata, vecs[i].miso, 400);
            chk($sformatf("v%0d_nbytes", i), 64'(nmosi), 64'(vecs[i].nbytes));
            chk($sformatf("v%0d_mosi", i), 64'(mosi), 64'(vecs[i].mosi));
            chk($sformatf("v%0d_nrsp", i), 64'(nrsp), 64'd1);
            chk($sformatf("v%0d_rdata", i), 64'(last_rdata), 64'(vecs[i].rdata));
            chk($sformatf("v%0d_rdata_hold", i), 64'(rsp_rdata), 64'(vecs[i].rdata));
            chk($sformatf("v%0d_err", i), 64'(last_err), 64'd0);
            chk($sformatf("v%0d_cs_rise", i), 64'(ncs_rise), 64'd1);
            chk($sformatf("v%0d_cs_start", i), 64'(cs_bad), 64'd0);
            chk($sformatf("v%0d_setup", i), 64'(setup_cnt), 64'd2);
            chk($sformatf("v%0d_hold", i), 64'(hold_cnt), 64'd2);
        end

        // cmd_valid held high: one accept per frame, next only after DONE
        @(posedge clk); #1;
        clear_mon();
        miso_q = '0;
        cmd_rw = 1'b0; cmd_addr = 7'h2A; cmd_len = 3'd1; cmd_wdata = 32'h77; cmd_valid = 1'b1;
        n = 0;
        while (nacc < 2 && n < 400) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (nrsp < 2 && n < 400) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #1;
        chk("hold_nacc", 64'(nacc), 64'd2);
        chk("hold_nrsp", 64'(nrsp), 64'd2);
        chk("hold_nbytes", 64'(nmosi), 64'd4);
        chk("hold_reaccept", 64'(acc_cyc[1]), 64'(rsp_cyc[0] + 1));

        // Reset during WAIT of data byte 1 aborts silently
        @(posedge clk); #1;
        clear_mon();
        miso_q = 40'h0000003C00;
        cmd_rw = 1'b1; cmd_addr = 7'h11; cmd_len = 3'd2; cmd_wdata = '0; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (nmosi < 2 && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_cs_n", 64'(cs_n), 64'd1);
        chk("midrst_spi_start", 64'(spi_start), 64'd0);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_rsp", 64'(nrsp), 64'd0);
        run_cmd(vecs[0].rw, vecs[0].addr, vecs[0].len, vecs[0].wdata, vecs[0].miso, 400);
        chk("postrst_mosi", 64'(mosi), 64'(vecs[0].mosi));
        chk("postrst_nrsp", 64'(nrsp), 64'd1);

        // Master never reports the second data byte
        drop_idx = 2;
        run_cmd(1'b1, 7'h10, 3'd2, 32'h0, 40'h00005A00, 150);
`ifdef SPI_SEQ_TIMEOUT_EN
        chk("tmo_nrsp", 64'(nrsp), 64'd1);
        chk("tmo_err", 64'(last_err), 64'd1);
        chk("tmo_rdata", 64'(last_rdata), 64'h5A);
        chk("tmo_cs_n", 64'(cs_n), 64'd1);
        drop_idx = -1;
`else
        chk("stuck_nrsp", 64'(nrsp), 64'd0);
        chk("stuck_cs_n", 64'(cs_n), 64'd0);
        chk("stuck_cmd_ready", 64'(cmd_ready), 64'd0);
        drop_idx = -1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("stuck_rst_cs_n", 64'(cs_n), 64'd1);
`endif
        run_cmd(vecs[1].rw, vecs[1].addr, vecs[1].len, vecs[1].wdata, vecs[1].miso, 400);
        chk("final_rdata", 64'(last_rdata), 64'(vecs[1].rdata));
        chk("final_err", 64'(last_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
